uart_transmitter: RTL

Serial transmitter for the UART link: accepts a parallel byte through a valid/ready handshake and drives one frame on the serial line. A frame is one start bit (0), eight data bits LSB first, one odd-parity bit, and STOP_BITS stop bits (1). It is the transmit end matching the team's UART receiver: 8x oversampling, odd parity, at least one stop bit. It sits between the byte source (CPU/FIFO) and the TX pin.

---
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmit end: start bit, eight data bits LSB first, odd parity, STOP_BITS stop bits.
// Bytes arrive over a send/ready handshake and the serial line is driven from a register.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 40,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       send,
    input  logic       par_err,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      r_state;
    state_t      w_stateNext;
    logic [7:0]  r_shift;
    logic [7:0]  w_shiftNext;
    logic [2:0]  r_bitIdx;
    logic [2:0]  w_bitIdxNext;
    logic [15:0] r_baudCnt;
    logic [15:0] w_baudCntNext;
    logic        r_stopCnt;
    logic        w_stopCntNext;
    logic        r_parity;
    logic        w_parityNext;
    logic        r_out;
    logic        w_outNext;
    logic        r_done;
    logic        w_doneNext;
    logic        w_accept;
    logic        w_baudTick;

    // ready is gated by reset so no byte can be accepted while reset is held.
    assign ready      = (r_state == IDLE) && reset;
    assign busy       = (r_state != IDLE);
    assign out        = r_out;
    assign done       = r_done;
    assign w_accept   = send && ready;
    assign w_baudTick = (r_baudCnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= 8'h00;
            r_bitIdx  <= 3'd0;
            r_baudCnt <= 16'd0;
            r_stopCnt <= 1'b0;
            r_parity  <= 1'b0;
            r_out     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_shift   <= w_shiftNext;
            r_bitIdx  <= w_bitIdxNext;
            r_baudCnt <= w_baudCntNext;
            r_stopCnt <= w_stopCntNext;
            r_parity  <= w_parityNext;
            r_out     <= w_outNext;
            r_done    <= w_doneNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_shiftNext   = r_shift;
        w_bitIdxNext  = r_bitIdx;
        w_baudCntNext = r_baudCnt;
        w_stopCntNext = r_stopCnt;
        w_parityNext  = r_parity;
        w_doneNext    = 1'b0;
        w_outNext     = 1'b1;

        if (r_state != IDLE) begin
            w_baudCntNext = w_baudTick ? 16'd0 : r_baudCnt + 16'd1;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shiftNext   = data_in;
                    w_parityNext  = ~^data_in ^ par_err;
                    w_baudCntNext = 16'd0;
                    w_bitIdxNext  = 3'd0;
                    w_stopCntNext = 1'b0;
                    w_stateNext   = START;
                end
            end
            START: begin
                if (w_baudTick) begin
                    w_bitIdxNext = 3'd0;
                    w_stateNext  = DATA;
                end
            end
            DATA: begin
                if (w_baudTick) begin
                    w_shiftNext = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = PARITY;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_baudTick) begin
                    w_stopCntNext = 1'b0;
                    w_stateNext   = STOP;
                end
            end
            STOP: begin
                if (w_baudTick) begin
                    if (r_stopCnt == STOP_LAST) begin
                        w_stateNext = IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_stopCntNext = r_stopCnt + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // The line level is registered, so it is decoded from the state being entered.
        case (w_stateNext)
            START:   w_outNext = 1'b0;
            DATA:    w_outNext = w_shiftNext[0];
            PARITY:  w_outNext = w_parityNext;
            default: w_outNext = 1'b1;
        endcase
    end

endmodule
